// File: rtl/mt_arbiter_if.sv
// Requester-side bundle of mt_arbiter: draw requests, reseed control and grant/result outputs.
interface mt_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0] req;
  logic            reseed;
  logic [31:0]     seed_in;
  logic [NREQ-1:0] gnt_valid;
  logic [31:0]     r_data;
  logic            busy;
  logic [31:0]     draw_cnt;

  modport master (
    output req, reseed, seed_in,
    input  gnt_valid, r_data, busy, draw_cnt
  );

  modport slave (
    input  req, reseed, seed_in,
    output gnt_valid, r_data, busy, draw_cnt
  );
endinterface

// File: rtl/mt_arbiter.sv
// Round-robin sharing of one MTwister among NREQ requesters; sequences twister
// reset/seeding, waits out regeneration, and issues one trig per granted draw.
module mt_arbiter #(
  parameter int unsigned NREQ         = 4,
  parameter logic [31:0] SEED_DEFAULT = 32'd5489,
  parameter int unsigned SETTLE_CYC   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  mt_arbiter_if.slave bus,
  output logic        mt_rst,
  output logic [31:0] mt_seed,
  output logic        mt_trig,
  input  logic [31:0] mt_num,
  input  logic        mt_ready
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(SETTLE_CYC + 1);

  typedef enum logic [1:0] {
    ST_SEED,
    ST_WAIT,
    ST_IDLE,
    ST_SETTLE
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     seed_q, seed_d;
  logic            reseed_pend_q, reseed_pend_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [31:0]     r_data_q, r_data_d;
  logic [31:0]     draw_cnt_q, draw_cnt_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   settle_cnt_q, settle_cnt_d;

  logic            gnt_found;
  logic [PW-1:0]   gnt_idx;
  logic [PW-1:0]   cand_idx;
  int unsigned     cand;
  logic            reseed_now;
  logic            grant_go;

  // First asserted request at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = 32'(rr_ptr_q) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = PW'(cand);
      if (!gnt_found && bus.req[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

  // A reseed pulse arriving in the same IDLE cycle as a request pre-empts the grant.
  assign reseed_now = reseed_pend_q || bus.reseed;
  assign grant_go   = (state_q == ST_IDLE) && !reseed_now && mt_ready && gnt_found;

  always_comb begin
    state_d      = state_q;
    seed_d       = seed_q;
    gnt_d        = '0;
    r_data_d     = r_data_q;
    draw_cnt_d   = draw_cnt_q;
    rr_ptr_d     = rr_ptr_q;
    settle_cnt_d = settle_cnt_q;

    if (bus.reseed) seed_d = bus.seed_in;
    // Any pending or fresh reseed seen in IDLE is serviced right there.
    reseed_pend_d = (state_q == ST_IDLE) ? 1'b0 : (reseed_pend_q || bus.reseed);

    unique case (state_q)
      ST_SEED: state_d = ST_WAIT;
      ST_WAIT: if (mt_ready) state_d = ST_IDLE;
      ST_IDLE: begin
        if (reseed_now) begin
          draw_cnt_d = '0;
          state_d    = ST_SEED;
        end else if (grant_go) begin
          r_data_d          = mt_num;
          gnt_d[gnt_idx]    = 1'b1;
          rr_ptr_d          = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
          draw_cnt_d        = draw_cnt_q + 32'd1;
          settle_cnt_d      = '0;
          state_d           = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_q == CW'(SETTLE_CYC - 1)) begin
          state_d = ST_IDLE;
        end else begin
          settle_cnt_d = settle_cnt_q + CW'(1);
        end
      end
      default: state_d = ST_SEED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_SEED;
      seed_q        <= SEED_DEFAULT;
      reseed_pend_q <= 1'b0;
      gnt_q         <= '0;
      r_data_q      <= '0;
      draw_cnt_q    <= '0;
      rr_ptr_q      <= '0;
      settle_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      seed_q        <= seed_d;
      reseed_pend_q <= reseed_pend_d;
      gnt_q         <= gnt_d;
      r_data_q      <= r_data_d;
      draw_cnt_q    <= draw_cnt_d;
      rr_ptr_q      <= rr_ptr_d;
      settle_cnt_q  <= settle_cnt_d;
    end
  end

  assign mt_rst        = !rst_n || (state_q == ST_SEED);
  assign mt_seed       = seed_q;
  assign mt_trig       = grant_go;
  assign bus.gnt_valid = gnt_q;
  assign bus.r_data    = r_data_q;
  assign bus.draw_cnt  = draw_cnt_q;
  assign bus.busy      = (state_q != ST_IDLE) || !mt_ready;

endmodule
